adder_op_sequencer: RTL and testbench
=====================================

// Module: adder_op_sequencer
// PURPOSE
//  Upstream issue/capture controller for the dynamic 32-bit adder. Accepts operands over a
//  valid/ready handshake and holds them stable at the adder inputs. Pulses the adder's F
//  ("first") signal, then waits for the adder's completion (ready) indication, or a watchdog
//  limit, whichever comes first. Captures sum/carry into an output register offered downstream
//  over valid/ready, so the asynchronous-timed adder appears as a variable-latency
//  synchronous unit.
// PARAMETERS
//  WIDTH     32  operand/sum width
//  MIN_WAIT  1   first WAIT cycle (count value) at which add_done is honoured; masks stale ready
//  MAX_WAIT  8   WAIT count at which capture is forced and timeout flagged; 1<=MIN_WAIT<=MAX_WAIT
//  CNT_W     4   width of wait counter/out_cycles; must hold MAX_WAIT
//  TO_W      16  width of saturating timeout statistics counter
// PORTS
//  adder_clk    in   1      sole clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      operand offer
//  in_ready     out  1      sequencer can accept operands
//  in_a, in_b   in   WIDTH  operands
//  in_cin       in   1      carry-in
//  add_a, add_b out  WIDTH  registered operands to adder
//  add_cin      out  1      registered carry-in to adder
//  add_f        out  1      F pulse: restarts adder timer
//  add_request  out  1      high while result is awaited
//  add_done     in   1      adder completion (R / ready)
//  add_sum      in   WIDTH  adder sum
//  add_cout     in   1      adder carry-out
//  out_valid    out  1      result offer
//  out_ready    in   1      downstream accepts result
//  out_sum      out  WIDTH  captured sum
//  out_cout     out  1      captured carry-out
//  out_timeout  out  1      result forced by watchdog (not completion)
//  out_cycles   out  CNT_W  WAIT cycles taken (1..MAX_WAIT)
//  timeout_cnt  out  TO_W   saturating count of timeouts since reset
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE, every output and register 0, including in_ready.
//   in_ready rises on first adder_clk edge after release.
//  FSM: IDLE -> LAUNCH -> WAIT -> HOLD -> IDLE; all outputs registered.
//  IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b/in_cin into add_a/add_b/add_cin;
//   go to LAUNCH; in_ready=0 from next cycle.
//  LAUNCH (1 cycle): add_f=1, add_request=0, cnt<=1; add_done ignored -> WAIT.
//  WAIT: add_request=1, add_f=0. Each cycle evaluate:
//   done_ok = add_done && cnt>=MIN_WAIT; force = (cnt==MAX_WAIT).
//   done_ok|force: out_sum<=add_sum, out_cout<=add_cout, out_cycles<=cnt;
//    out_timeout<=force&~done_ok; -> HOLD.
//   Otherwise cnt<=cnt+1. Both true in same cycle: completion wins, out_timeout=0.
//  HOLD: out_valid=1, add_request=0; out_* stable; in_valid ignored.
//   On out_ready -> IDLE; out_valid=0 and in_ready=1 next cycle. out_* keep last values.
//  add_a/add_b/add_cin remain constant from LAUNCH through HOLD, never change mid-add.
//  Timeout: timeout_cnt +1 per forced capture, saturates at all-ones, never wraps.
//  Latency: accept at edge k -> LAUNCH k+1 -> earliest out_valid k+2+MIN_WAIT; max k+2+MAX_WAIT.
//   Issue at most one op per 4 cycles.
//  Reset mid-op: op abandoned, no out_valid after release, timeout_cnt cleared.
// TESTING
//  1 MIN_WAIT=1: in_a=1,in_b=2,cin=0; add_done=1 first WAIT cycle
//    -> out_sum=3,cout=0,cycles=1,timeout=0.
//  2 in_a=FFFFFFFF,in_b=1; add_done at 4th WAIT cycle -> out_sum=0,cout=1,cycles=4,timeout=0;
//    add_f high exactly 1 cycle.
//  3 add_done held 0 -> capture at cnt=8: out_timeout=1, out_cycles=8, timeout_cnt=1;
//    add_done and cnt=8 together -> timeout=0.
//  4 HOLD with out_ready=0 for 5 cycles, in_valid=1 -> out_* stable, in_ready=0,
//    no operand change; out_ready=1 -> IDLE.
//  5 MIN_WAIT=2, add_done=1 in LAUNCH and cnt=1 -> ignored; capture at cnt=2, cycles=2.
//  6 rst_n low during WAIT -> outputs 0 immediately; after release in_ready=1,
//    no spurious out_valid; TO_W=2 with 4 timeouts -> timeout_cnt=3.

Source files
------------

// File: rtl/adder_op_sequencer.sv
// Issue/capture controller that wraps the self-timed 32-bit adder in a valid/ready shell
// so it behaves as a variable-latency synchronous unit with a watchdog.
module adder_op_sequencer #(
    parameter int WIDTH    = 32,
    parameter int MIN_WAIT = 1,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 4,
    parameter int TO_W     = 16
) (
    input  logic             adder_clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             add_f,
    output logic             add_request,
    input  logic             add_done,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_timeout,
    output logic [CNT_W-1:0] out_cycles,
    output logic [TO_W-1:0]  timeout_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             done_ok;
    logic             force_cap;
    logic             capture;

    always_comb begin
        accept     = 1'b0;
        done_ok    = 1'b0;
        force_cap  = 1'b0;
        capture    = 1'b0;
        state_next = state;
        case (state)
            S_IDLE: begin
                accept = in_valid && in_ready;
                if (accept) state_next = S_LAUNCH;
            end
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                // A ready seen before MIN_WAIT may be left over from the previous add.
                done_ok   = add_done && (cnt >= CNT_W'(MIN_WAIT));
                force_cap = (cnt == CNT_W'(MAX_WAIT));
                capture   = done_ok || force_cap;
                if (capture) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge adder_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake strobes are decoded from the next state so every output comes off a flop.
    always_ff @(posedge adder_clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready    <= 1'b0;
            add_f       <= 1'b0;
            add_request <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            in_ready    <= (state_next == S_IDLE);
            add_f       <= (state_next == S_LAUNCH);
            add_request <= (state_next == S_WAIT);
            out_valid   <= (state_next == S_HOLD);
        end
    end

    always_ff @(posedge adder_clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a       <= '0;
            add_b       <= '0;
            add_cin     <= 1'b0;
            cnt         <= '0;
            out_sum     <= '0;
            out_cout    <= 1'b0;
            out_timeout <= 1'b0;
            out_cycles  <= '0;
            timeout_cnt <= '0;
        end else begin
            if (accept) begin
                add_a   <= in_a;
                add_b   <= in_b;
                add_cin <= in_cin;
            end
            if (state == S_LAUNCH) begin
                cnt <= CNT_W'(1);
            end else if ((state == S_WAIT) && !capture) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture) begin
                out_sum     <= add_sum;
                out_cout    <= add_cout;
                out_cycles  <= cnt;
                out_timeout <= force_cap && !done_ok;
                if (force_cap && !done_ok && (timeout_cnt != {TO_W{1'b1}})) begin
                    timeout_cnt <= timeout_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Bench for adder_op_sequencer: two instances (MIN_WAIT=1/TO_W=16 and MIN_WAIT=2/TO_W=2)
// checked every cycle against an operation-level model plus hand-computed results.
module tb_adder_op_sequencer;

    localparam int W        = 32;
    localparam int CW       = 4;
    localparam int MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          chk_en = 1'b0;
    logic          in_valid    [2];
    logic          in_ready    [2];
    logic [W-1:0]  in_a        [2];
    logic [W-1:0]  in_b        [2];
    logic          in_cin      [2];
    logic [W-1:0]  add_a       [2];
    logic [W-1:0]  add_b       [2];
    logic          add_cin     [2];
    logic          add_f       [2];
    logic          add_request [2];
    logic          add_done    [2];
    logic [W-1:0]  add_sum     [2];
    logic          add_cout    [2];
    logic          out_valid   [2];
    logic          out_ready   [2];
    logic [W-1:0]  out_sum     [2];
    logic          out_cout    [2];
    logic          out_timeout [2];
    logic [CW-1:0] out_cycles  [2];
    logic [15:0]   tcnt0;
    logic [1:0]    tcnt1;

    int n_checks = 0;
    int n_errors = 0;
    int f_count  = 0;

    always #5 clk = ~clk;

    adder_op_sequencer #(.WIDTH(W), .MIN_WAIT(1), .MAX_WAIT(MAX_WAIT), .CNT_W(CW), .TO_W(16)) u0 (
        .adder_clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_cin(in_cin[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
        .add_f(add_f[0]), .add_request(add_request[0]), .add_done(add_done[0]),
        .add_sum(add_sum[0]), .add_cout(add_cout[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_cout(out_cout[0]), .out_timeout(out_timeout[0]),
        .out_cycles(out_cycles[0]), .timeout_cnt(tcnt0)
    );

    adder_op_sequencer #(.WIDTH(W), .MIN_WAIT(2), .MAX_WAIT(MAX_WAIT), .CNT_W(CW), .TO_W(2)) u1 (
        .adder_clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_cin(in_cin[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
        .add_f(add_f[1]), .add_request(add_request[1]), .add_done(add_done[1]),
        .add_sum(add_sum[1]), .add_cout(add_cout[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_cout(out_cout[1]), .out_timeout(out_timeout[1]),
        .out_cycles(out_cycles[1]), .timeout_cnt(tcnt1)
    );

    function automatic int min_wait(input int g);
        return (g == 0) ? 1 : 2;
    endfunction

    function automatic logic [15:0] to_max(input int g);
        return (g == 0) ? 16'hFFFF : 16'h0003;
    endfunction

    function automatic logic [15:0] tcnt_of(input int g);
        return (g == 0) ? tcnt0 : {14'b0, tcnt1};
    endfunction

    // The adder only presents the true result once it signals completion; before that the bus is garbage.
    function automatic logic [W:0] adder_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic cin, input logic done);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return done ? full : ~full;
    endfunction

    logic [W:0] adder_bus [2];
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            adder_bus[g] = adder_result(add_a[g], add_b[g], add_cin[g], add_done[g]);
            add_sum[g]   = adder_bus[g][W-1:0];
            add_cout[g]  = adder_bus[g][W];
        end
    end

    // Operation-level model: where each instance is in its current op and what it must present.
    logic          e_rdy   [2];
    logic          e_f     [2];
    logic          e_req   [2];
    logic          e_val   [2];
    logic [W-1:0]  e_a     [2];
    logic [W-1:0]  e_b     [2];
    logic          e_cin   [2];
    logic [W:0]    e_res   [2];
    logic          e_to    [2];
    logic [CW-1:0] e_cyc   [2];
    logic [15:0]   e_tocnt [2];
    int            waited  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                e_rdy[g] <= 0; e_f[g] <= 0; e_req[g] <= 0; e_val[g] <= 0;
                e_a[g] <= '0; e_b[g] <= '0; e_cin[g] <= 0; e_res[g] <= '0;
                e_to[g] <= 0; e_cyc[g] <= '0; e_tocnt[g] <= '0; waited[g] <= 0;
            end else if (e_val[g]) begin
                if (out_ready[g]) begin
                    e_val[g] <= 0;
                    e_rdy[g] <= 1;
                end
            end else if (e_f[g]) begin
                e_f[g]   <= 0;
                e_req[g] <= 1;
                waited[g] <= 1;
            end else if (e_req[g]) begin
                if ((add_done[g] && waited[g] >= min_wait(g)) || waited[g] == MAX_WAIT) begin
                    e_req[g] <= 0;
                    e_val[g] <= 1;
                    e_res[g] <= adder_result(e_a[g], e_b[g], e_cin[g], add_done[g]);
                    e_cyc[g] <= CW'(waited[g]);
                    e_to[g]  <= !add_done[g];
                    if (!add_done[g] && e_tocnt[g] != to_max(g)) e_tocnt[g] <= e_tocnt[g] + 16'd1;
                end else begin
                    waited[g] <= waited[g] + 1;
                end
            end else if (e_rdy[g]) begin
                if (in_valid[g]) begin
                    e_rdy[g] <= 0;
                    e_f[g]   <= 1;
                    e_a[g]   <= in_a[g];
                    e_b[g]   <= in_b[g];
                    e_cin[g] <= in_cin[g];
                end
            end else begin
                e_rdy[g] <= 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                checkOutput($sformatf("u%0d.in_ready", g), 64'(in_ready[g]), 64'(e_rdy[g]));
                checkOutput($sformatf("u%0d.add_f", g), 64'(add_f[g]), 64'(e_f[g]));
                checkOutput($sformatf("u%0d.add_request", g), 64'(add_request[g]), 64'(e_req[g]));
                checkOutput($sformatf("u%0d.out_valid", g), 64'(out_valid[g]), 64'(e_val[g]));
                checkOutput($sformatf("u%0d.out_sum", g), 64'(out_sum[g]), 64'(e_res[g][W-1:0]));
                checkOutput($sformatf("u%0d.out_cout", g), 64'(out_cout[g]), 64'(e_res[g][W]));
                checkOutput($sformatf("u%0d.out_timeout", g), 64'(out_timeout[g]), 64'(e_to[g]));
                checkOutput($sformatf("u%0d.out_cycles", g), 64'(out_cycles[g]), 64'(e_cyc[g]));
                checkOutput($sformatf("u%0d.timeout_cnt", g), 64'(tcnt_of(g)), 64'(e_tocnt[g]));
                if (e_f[g] || e_req[g] || e_val[g]) begin
                    checkOutput($sformatf("u%0d.add_a", g), 64'(add_a[g]), 64'(e_a[g]));
                    checkOutput($sformatf("u%0d.add_b", g), 64'(add_b[g]), 64'(e_b[g]));
                    checkOutput($sformatf("u%0d.add_cin", g), 64'(add_cin[g]), 64'(e_cin[g]));
                end
            end
            if (add_f[0]) f_count <= f_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full operation: handshake in, drive add_done per WAIT count from done_mask
    // (bit 0 = LAUNCH cycle), linger in HOLD for hold_cycles, then release the result.
    task automatic applyStimulus(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [15:0] done_mask,
                                 input int hold_cycles, input logic poke_in);
        int guard;
        in_a[g] = a; in_b[g] = b; in_cin[g] = cin; in_valid[g] = 1;
        guard = 0;
        while (in_ready[g] !== 1'b1 && guard < 12) begin
            tick();
            guard++;
        end
        checkOutput($sformatf("u%0d.accept_bound", g), 64'(in_ready[g]), 64'd1);
        tick();
        in_valid[g] = 0; in_a[g] = ~a; in_b[g] = ~b; in_cin[g] = ~cin;
        for (int n = 0; n < 14; n++) begin
            add_done[g] = done_mask[n];
            tick();
            if (out_valid[g] === 1'b1) break;
        end
        add_done[g] = 0;
        checkOutput($sformatf("u%0d.result_bound", g), 64'(out_valid[g]), 64'd1);
        in_valid[g] = poke_in;
        repeat (hold_cycles) tick();
        out_ready[g] = 1;
        tick();
        out_ready[g] = 0;
        in_valid[g] = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int f_base;
        rst_n = 1;
        for (int g = 0; g < 2; g++) begin
            in_valid[g] = 0; in_a[g] = '0; in_b[g] = '0; in_cin[g] = 0;
            add_done[g] = 0; out_ready[g] = 0;
        end
        #1 rst_n = 0;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.in_ready", 64'(in_ready[0]), 64'd0);
        checkOutput("reset.timeout_cnt", 64'(tcnt0), 64'd0);
        #1 rst_n = 1;
        tick();
        checkOutput("release.in_ready", 64'(in_ready[0]), 64'd1);

        // 1: fastest completion
        applyStimulus(0, 32'd1, 32'd2, 1'b0, 16'h0002, 0, 1'b0);
        checkOutput("t1.sum", 64'(out_sum[0]), 64'd3);
        checkOutput("t1.cout", 64'(out_cout[0]), 64'd0);
        checkOutput("t1.cycles", 64'(out_cycles[0]), 64'd1);
        checkOutput("t1.timeout", 64'(out_timeout[0]), 64'd0);

        // 2: wrap-around with carry, completion on the 4th WAIT cycle
        f_base = f_count;
        applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 16'h0010, 1, 1'b0);
        checkOutput("t2.sum", 64'(out_sum[0]), 64'd0);
        checkOutput("t2.cout", 64'(out_cout[0]), 64'd1);
        checkOutput("t2.cycles", 64'(out_cycles[0]), 64'd4);
        checkOutput("t2.timeout", 64'(out_timeout[0]), 64'd0);
        checkOutput("t2.f_pulses", 64'(f_count - f_base), 64'd1);

        // 3: watchdog, then completion landing exactly on the limit
        applyStimulus(0, 32'd5, 32'd6, 1'b0, 16'h0000, 0, 1'b0);
        checkOutput("t3a.timeout", 64'(out_timeout[0]), 64'd1);
        checkOutput("t3a.cycles", 64'(out_cycles[0]), 64'd8);
        checkOutput("t3a.timeout_cnt", 64'(tcnt0), 64'd1);
        applyStimulus(0, 32'd10, 32'd20, 1'b1, 16'h0100, 0, 1'b0);
        checkOutput("t3b.timeout", 64'(out_timeout[0]), 64'd0);
        checkOutput("t3b.cycles", 64'(out_cycles[0]), 64'd8);
        checkOutput("t3b.sum", 64'(out_sum[0]), 64'd31);
        checkOutput("t3b.timeout_cnt", 64'(tcnt0), 64'd1);

        // 4: downstream stalls with a new offer pending
        applyStimulus(0, 32'h1234_5678, 32'h0000_1111, 1'b1, 16'h0004, 5, 1'b1);
        checkOutput("t4.sum", 64'(out_sum[0]), 64'h1234_678A);
        checkOutput("t4.cycles", 64'(out_cycles[0]), 64'd2);
        checkOutput("t4.idle_ready", 64'(in_ready[0]), 64'd1);

        // 5: early ready masked by MIN_WAIT=2
        applyStimulus(1, 32'd100, 32'd23, 1'b0, 16'h0007, 0, 1'b0);
        checkOutput("t5.cycles", 64'(out_cycles[1]), 64'd2);
        checkOutput("t5.sum", 64'(out_sum[1]), 64'd123);
        checkOutput("t5.timeout", 64'(out_timeout[1]), 64'd0);

        // 6: reset in the middle of a WAIT
        in_a[1] = 32'hDEAD_BEEF; in_b[1] = 32'h0000_0001; in_cin[1] = 0; in_valid[1] = 1;
        tick();
        in_valid[1] = 0;
        repeat (4) tick();
        checkOutput("t6.pre_request", 64'(add_request[1]), 64'd1);
        rst_n = 0;
        #1;
        checkOutput("t6.rst_request", 64'(add_request[1]), 64'd0);
        checkOutput("t6.rst_add_a", 64'(add_a[1]), 64'd0);
        checkOutput("t6.rst_timeout_cnt0", 64'(tcnt0), 64'd0);
        tick();
        rst_n = 1;
        tick();
        checkOutput("t6.release_ready", 64'(in_ready[1]), 64'd1);
        repeat (10) tick();
        checkOutput("t6.no_spurious_valid", 64'(out_valid[1]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'(i), 32'd7, 1'b0, 16'h0000, 0, 1'b0);
        end
        checkOutput("t6.timeout_saturate", 64'(tcnt1), 64'd3);
        checkOutput("t6.last_timeout", 64'(out_timeout[1]), 64'd1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
